// File: rtl/mem_io_bus.sv
// Bus stage behind the multicycle processor: RAM, LEDR, synchronized SW, status/control and Run sequencer.
// Optional instruction counter at 0x3001 is built when INSTR_COUNT_EN is defined.
module mem_io_bus #(
    parameter int RAM_AW = 7,
    parameter int LED_W  = 10,
    parameter int SW_W   = 10
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic [15:0]       ADDR,
    input  logic [15:0]       DOUT,
    input  logic              W,
    input  logic              Done,
    input  logic              Start,
    input  logic [SW_W-1:0]   SW,
    output logic [15:0]       DIN,
    output logic              Run,
    output logic [LED_W-1:0]  LEDR
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HALT = 2'b10
    } state_t;

    logic [15:0]       r_mem [0:2**RAM_AW-1];
    logic [15:0]       r_din;
    logic [LED_W-1:0]  r_ledr;
    logic [SW_W-1:0]   r_sw_meta;
    logic [SW_W-1:0]   r_sw_sync;
    logic              r_start_meta;
    logic              r_start_sync;
    logic              r_start_prev;
    state_t            r_state;
    logic              r_run;

    logic [3:0]        w_region;
    logic [RAM_AW-1:0] w_ram_idx;
    logic [15:0]       w_rd_data;
    logic [15:0]       w_icount;
    logic              w_start_evt;
    logic              w_halt_req;

    assign w_region    = ADDR[15:12];
    assign w_ram_idx   = ADDR[RAM_AW-1:0];
    assign w_start_evt = r_start_sync & ~r_start_prev;
    assign w_halt_req  = W && (w_region == 4'hF) && DOUT[0];

    assign DIN  = r_din;
    assign Run  = r_run;
    assign LEDR = r_ledr;

    // RAM is not reset; the read port samples before the write lands (read-first).
    always_ff @(posedge Clock) begin
        if (W && (w_region == 4'h0)) begin
            r_mem[w_ram_idx] <= DOUT;
        end
    end

    always_comb begin
        w_rd_data = 16'h0000;
        case (w_region)
            4'h0: w_rd_data = r_mem[w_ram_idx];
            4'h1: w_rd_data = 16'(r_ledr);
            4'h2: w_rd_data = 16'(r_sw_sync);
            4'h3: begin
                if (ADDR[11:0] == 12'h000) begin
                    w_rd_data = {14'b0, r_state};
                end else if (ADDR[11:0] == 12'h001) begin
                    w_rd_data = w_icount;
                end
            end
            default: w_rd_data = 16'h0000;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_din        <= 16'h0000;
            r_ledr       <= '0;
            r_sw_meta    <= '0;
            r_sw_sync    <= '0;
            r_start_meta <= 1'b0;
            r_start_sync <= 1'b0;
            r_start_prev <= 1'b0;
            r_state      <= ST_IDLE;
            r_run        <= 1'b0;
        end else begin
            r_din        <= w_rd_data;
            r_sw_meta    <= SW;
            r_sw_sync    <= r_sw_meta;
            r_start_meta <= Start;
            r_start_sync <= r_start_meta;
            r_start_prev <= r_start_sync;
            if (W && (w_region == 4'h1)) begin
                r_ledr <= DOUT[LED_W-1:0];
            end
            // Start events are ignored while running, so a coincident halt write wins.
            case (r_state)
                ST_IDLE, ST_HALT: begin
                    if (w_start_evt) begin
                        r_state <= ST_RUN;
                        r_run   <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (w_halt_req) begin
                        r_state <= ST_HALT;
                        r_run   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_run   <= 1'b0;
                end
            endcase
        end
    end

`ifdef INSTR_COUNT_EN
    logic [15:0] r_icount;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_icount <= 16'h0000;
        end else if (Done && r_run && (r_icount != 16'hFFFF)) begin
            r_icount <= r_icount + 16'd1;
        end
    end

    assign w_icount = r_icount;
`else
    logic w_unused;

    assign w_icount = 16'h0000;
    assign w_unused = Done;
`endif

endmodule

// File: tb/tb_mem_io_bus.sv
// Self-checking bench for mem_io_bus: directed sequence with randomized data against an address-map model.
module tb_mem_io_bus;

    localparam int RAM_AW = 7;
    localparam int LED_W  = 10;
    localparam int SW_W   = 10;

    logic              Clock = 1'b0;
    logic              Resetn;
    logic [15:0]       ADDR;
    logic [15:0]       DOUT;
    logic              W;
    logic              Done;
    logic              Start;
    logic [SW_W-1:0]   SW;
    logic [15:0]       DIN;
    logic              Run;
    logic [LED_W-1:0]  LEDR;

    int checks   = 0;
    int failures = 0;

    logic [15:0]       mem_m [0:2**RAM_AW-1];
    logic [LED_W-1:0]  led_m;
    logic [SW_W-1:0]   sw_m;
    logic [15:0]       state_m;
    logic [15:0]       cnt_m;
    logic [15:0]       written_q [$];

    mem_io_bus #(.RAM_AW(RAM_AW), .LED_W(LED_W), .SW_W(SW_W)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .ADDR   (ADDR),
        .DOUT   (DOUT),
        .W      (W),
        .Done   (Done),
        .Start  (Start),
        .SW     (SW),
        .DIN    (DIN),
        .Run    (Run),
        .LEDR   (LEDR)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] model_read(input logic [15:0] addr);
        case (addr[15:12])
            4'h0: return mem_m[addr[RAM_AW-1:0]];
            4'h1: return 16'(led_m);
            4'h2: return 16'(sw_m);
            4'h3: begin
                if (addr[11:0] == 12'h000) return state_m;
`ifdef INSTR_COUNT_EN
                if (addr[11:0] == 12'h001) return cnt_m;
`endif
                return 16'h0000;
            end
            default: return 16'h0000;
        endcase
    endfunction

    function automatic void model_write(input logic [15:0] addr, input logic [15:0] data);
        case (addr[15:12])
            4'h0: mem_m[addr[RAM_AW-1:0]] = data;
            4'h1: led_m = data[LED_W-1:0];
            4'hF: if (data[0] && state_m == 16'd1) state_m = 16'd2;
            default: ;
        endcase
    endfunction

    task automatic bus_write(input logic [15:0] addr, input logic [15:0] data);
        ADDR = addr;
        DOUT = data;
        W    = 1'b1;
        tick();
        W    = 1'b0;
        model_write(addr, data);
    endtask

    task automatic bus_read(input string tag, input logic [15:0] addr);
        logic [15:0] exp;
        exp  = model_read(addr);
        ADDR = addr;
        W    = 1'b0;
        tick();
        check(tag, DIN, exp);
    endtask

    // Assumes Start has been low long enough for the synchronizer to settle.
    task automatic press_start();
        Start = 1'b1;
        tick();
        check("start_sync1", 16'(Run), 16'(state_m == 16'd1));
        tick();
        check("start_sync2", 16'(Run), 16'(state_m == 16'd1));
        tick();
        state_m = 16'd1;
        check("start_run", 16'(Run), 16'h0001);
    endtask

    task automatic release_start();
        Start = 1'b0;
        repeat (3) tick();
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] d;
        logic [15:0] old;
        logic [SW_W-1:0] sw_v;

        Resetn = 1'b0;
        ADDR = 16'h0000; DOUT = 16'h0000; W = 1'b0;
        Done = 1'b0; Start = 1'b0; SW = '0;
        led_m = '0; sw_m = '0; state_m = 16'd0; cnt_m = 16'd0;
        for (int i = 0; i < 2**RAM_AW; i++) mem_m[i] = 16'hxxxx;

        // Reset state
        tick(); tick();
        check("rst_din", DIN, 16'h0000);
        check("rst_ledr", 16'(LEDR), 16'h0000);
        check("rst_run", 16'(Run), 16'h0000);
        Resetn = 1'b1;
        tick();
        bus_read("rst_status", 16'h3000);

        // RAM: directed write, latency-1 read, aliasing
        bus_write(16'h0005, 16'hBEEF);
        bus_read("ram_beef", 16'h0005);
        bus_read("ram_alias", 16'h0085);
        written_q.push_back(16'h0005);
        for (int i = 0; i < 16; i++) begin
            a = {4'h0, 12'($urandom_range(0, 4095))};
            d = 16'($urandom);
            bus_write(a, d);
            written_q.push_back(a);
        end
        for (int i = 0; i < 16; i++) begin
            a = written_q[$urandom_range(0, written_q.size() - 1)];
            a = {4'h0, 5'($urandom_range(0, 31)), a[RAM_AW-1:0]};
            bus_read("ram_rand", a);
        end
        a = written_q[0];
        old = model_read(a);
        bus_write(a, ~old);
        check("ram_read_first", DIN, old);
        bus_read("ram_after_rfw", a);
        bus_write(16'h7005, 16'h1234);
        bus_write(16'h2005, 16'h5678);
        bus_read("ram_unmapped_wr", 16'h0005);

        // LEDR, SW, unmapped reads
        bus_write(16'h1000, 16'hFFFF);
        check("ledr_all", 16'(LEDR), 16'h03FF);
        bus_read("ledr_read", 16'h1000);
        for (int i = 0; i < 3; i++) begin
            d = 16'($urandom);
            bus_write(16'h1000 | 16'($urandom_range(0, 4095)), d);
            check("ledr_rand", 16'(LEDR), 16'(d[LED_W-1:0]));
        end
        SW = 10'h2A5;
        tick(); tick();
        sw_m = 10'h2A5;
        bus_read("sw_2a5", 16'h2000);
        for (int i = 0; i < 3; i++) begin
            sw_v = SW_W'($urandom);
            SW = sw_v;
            tick(); tick();
            sw_m = sw_v;
            bus_read("sw_rand", 16'h2000);
        end
        bus_read("unmapped_7000", 16'h7000);
        bus_read("ctrl_read", 16'hF000);

        // Run sequencer: start, held Start gives one event, halt, resume
        press_start();
        tick(); tick();
        check("run_held", 16'(Run), 16'h0001);
        bus_read("status_run", 16'h3000);
        bus_write(16'hF000, 16'h0000);
        check("nohalt_bit0", 16'(Run), 16'h0001);
        bus_write(16'hF000, 16'h0001);
        check("halt_run", 16'(Run), 16'h0000);
        repeat (3) tick();
        check("held_start_no_rerun", 16'(Run), 16'h0000);
        bus_read("status_halt", 16'h3000);
        release_start();
        press_start();
        bus_read("status_resume", 16'h3000);

        // Coincident halt write and start event: halt wins
        release_start();
        Start = 1'b1;
        tick(); tick();
        bus_write(16'hF000, 16'h0001);
        check("race_run", 16'(Run), 16'h0000);
        bus_read("race_status", 16'h3000);

        // Reset while running drops Run and LEDR without a clock edge
        release_start();
        press_start();
        Start = 1'b0;
        bus_write(16'h1000, 16'h0155);
        check("ledr_155", 16'(LEDR), 16'h0155);
        Resetn = 1'b0;
        #1;
        check("async_run", 16'(Run), 16'h0000);
        check("async_ledr", 16'(LEDR), 16'h0000);
        check("async_din", DIN, 16'h0000);
        led_m = '0; state_m = 16'd0; cnt_m = 16'd0;
        #2;
        Resetn = 1'b1;
        repeat (3) tick();
        bus_read("post_rst_status", 16'h3000);
        bus_read("post_rst_ram", 16'h0005);

        // Instruction counter: Done only counts while running
        Done = 1'b1;
        tick(); tick();
        Done = 1'b0;
        press_start();
        for (int i = 0; i < 7; i++) begin
            Done = 1'b1;
            tick();
            cnt_m++;
            Done = 1'($urandom_range(0, 1));
            tick();
            if (Done) cnt_m++;
        end
        Done = 1'b0;
        bus_read("icount", 16'h3001);
        bus_write(16'hF000, 16'h0001);
        Done = 1'b1;
        tick(); tick();
        Done = 1'b0;
        bus_read("icount_halted", 16'h3001);
        bus_read("status_end", 16'h3000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
